// File: rtl/bus_pkg.sv
// Shared constants for the CPU bus target: I/O page offsets, ID byte,
// STATUS bit layout and a helper that packs the STATUS byte.
package bus_pkg;

  localparam logic [3:0] IO_TX_DATA  = 4'h0;
  localparam logic [3:0] IO_STATUS   = 4'h1;
  localparam logic [3:0] IO_TIMER_LO = 4'h2;
  localparam logic [3:0] IO_TIMER_HI = 4'h3;
  localparam logic [3:0] IO_ID       = 4'h4;

  localparam logic [7:0] ID_VALUE = 8'h91;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CNT   = 4;

  function automatic logic [7:0] status_byte(
    input logic [3:0] cnt,
    input logic       ovf,
    input logic       full,
    input logic       empty
  );
    logic [7:0] s;
    s = '0;
    s[ST_EMPTY]     = empty;
    s[ST_FULL]      = full;
    s[ST_OVF]       = ovf;
    s[ST_CNT +: 4]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/bus_responder_fifo.sv
// tx_fifo: circular-buffer FIFO with registered storage and wrapping pointers.
// Ports: clk, reset (sync, active-high); push/din/full; pop/dout/empty/count.
module tx_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_responder.sv
// bus_responder: sole target on the 8-bit CPU bus (RAM + 16-byte I/O page).
// Ports: clk, reset, address_bus, data_bus (inout), r, w, tx_*, bus_error.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_ADDR_W = 14,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_bus,
  inout  wire  [7:0]  data_bus,
  input  logic        r,
  input  logic        w,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_error
);

  localparam int RAM_SIZE = 1 << RAM_ADDR_W;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    mem [RAM_SIZE];
  logic [15:0]   timer;
  logic [7:0]    hi_latch;
  logic          overflow;
  logic [7:0]    rdata;
  logic [3:0]    offset;
  logic          sel_ram;
  logic          sel_io;
  logic          unmapped;
  logic          rd_ok;
  logic          wr_ok;
  logic          push;
  logic          pop;
  logic          f_full;
  logic          f_empty;
  logic [CW-1:0] f_count;

  assign offset   = address_bus[3:0];
  assign sel_ram  = {16'd0, address_bus} < 32'(RAM_SIZE);
  assign sel_io   = !sel_ram &&
                    (address_bus[15:4] == IO_BASE[15:4]);
  assign unmapped = !sel_ram && !sel_io;

  // r && w is a collision: neither a read nor a write.
  assign rd_ok = r && !w && !reset;
  assign wr_ok = w && !r && !reset;

  assign push     = wr_ok && sel_io && (offset == IO_TX_DATA);
  assign pop      = tx_valid && tx_ready;
  assign tx_valid = !f_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (data_bus),
    .full  (f_full),
    .pop   (pop),
    .dout  (tx_data),
    .empty (f_empty),
    .count (f_count)
  );

  always_ff @(posedge clk) begin
    if (wr_ok && sel_ram) begin
      mem[address_bus[RAM_ADDR_W-1:0]] <= data_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer     <= '0;
      hi_latch  <= '0;
      overflow  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      timer     <= timer + 16'd1;
      bus_error <= (r && w) || ((r || w) && unmapped);
      if ((rd_ok || wr_ok) && sel_io &&
          (offset == IO_TIMER_LO)) begin
        hi_latch <= timer[15:8];
      end
      if (push && f_full && !pop) begin
        overflow <= 1'b1;
      end else if (wr_ok && sel_io &&
                   (offset == IO_STATUS) &&
                   data_bus[ST_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      sel_ram: rdata = mem[address_bus[RAM_ADDR_W-1:0]];
      sel_io: begin
        case (offset)
          IO_STATUS:   rdata = status_byte(4'(f_count), overflow,
                                           f_full, f_empty);
          IO_TIMER_LO: rdata = timer[7:0];
          IO_TIMER_HI: rdata = hi_latch;
          IO_ID:       rdata = ID_VALUE;
          default:     rdata = 8'h00;
        endcase
      end
      default: rdata = 8'hFF;
    endcase
  end

  assign data_bus = rd_ok ? rdata : 8'bz;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: queue/array reference model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address_bus;
  logic        r;
  logic        w;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        bus_error;
  logic [7:0]  tb_d;
  logic        tb_de;
  wire  [7:0]  data_bus;

  assign data_bus = tb_de ? tb_d : 8'bz;

  bus_responder dut (
    .clk         (clk),
    .reset       (reset),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .r           (r),
    .w           (w),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .bus_error   (bus_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state as seen after the most recent clock edge.
  logic [7:0]  m_q [$];
  logic [7:0]  m_mem [int];
  logic [15:0] m_timer = 16'h0;
  logic [7:0]  m_hi = 8'h0;
  bit          m_ovf = 0;
  bit          m_err = 0;
  bit          m_ok = 0;

  function automatic bit is_ram(input logic [15:0] a);
    return a < 16'h4000;
  endfunction

  function automatic bit is_io(input logic [15:0] a);
    return a >= 16'hFF00 && a <= 16'hFF0F;
  endfunction

  function automatic logic [7:0] exp_read(input logic [15:0] a,
                                           output bit known);
    int n;
    known = 1;
    n = m_q.size();
    if (is_ram(a)) begin
      if (m_mem.exists(int'(a))) return m_mem[int'(a)];
      known = 0;
      return 8'h00;
    end
    if (!is_io(a)) return 8'hFF;
    case (a[3:0])
      4'h1: return {4'(n), 1'b0, m_ovf, n == 8, n == 0};
      4'h2: return m_timer[7:0];
      4'h3: return m_hi;
      4'h4: return 8'h91;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit popped;
    bit acc;
    if (reset) begin
      m_timer = 16'h0;
      m_hi    = 8'h0;
      m_ovf   = 0;
      m_err   = 0;
      m_q.delete();
      m_ok    = 1;
    end else begin
      popped = (m_q.size() > 0) && tx_ready;
      acc    = r ^ w;
      m_err  = (r && w) ||
               ((r || w) && !is_ram(address_bus) && !is_io(address_bus));
      if (popped) void'(m_q.pop_front());
      if (acc && is_io(address_bus)) begin
        if (address_bus[3:0] == 4'h2) m_hi = m_timer[15:8];
        if (w && address_bus[3:0] == 4'h0) begin
          if (m_q.size() < 8) m_q.push_back(data_bus);
          else m_ovf = 1;
        end
        if (w && address_bus[3:0] == 4'h1 && data_bus[2]) m_ovf = 0;
      end
      if (w && !r && is_ram(address_bus))
        m_mem[int'(address_bus)] = data_bus;
      m_timer = m_timer + 16'd1;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] e;
    bit known;
    if (m_ok) begin
      chk("tx_valid", {15'd0, tx_valid}, {15'd0, m_q.size() != 0});
      if (m_q.size() != 0) chk("tx_data", {8'd0, tx_data}, {8'd0, m_q[0]});
      chk("bus_error", {15'd0, bus_error}, {15'd0, m_err});
      if (r && !w && !reset) begin
        e = exp_read(address_bus, known);
        if (known) chk("read_data", {8'd0, data_bus}, {8'd0, e});
      end
    end
  end

  task automatic drive(input bit rr, input bit ww,
                       input logic [15:0] a, input logic [7:0] d);
    r = rr;
    w = ww;
    address_bus = a;
    tb_d = d;
    tb_de = ww;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0000, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    drive(0, 1, a, d);
    step();
    idle();
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a,
                        input logic [7:0] exp);
    drive(1, 0, a, 8'h00);
    @(negedge clk);
    chk(nm, {8'd0, data_bus}, {8'd0, exp});
    step();
    idle();
  endtask

  task automatic run_to(input logic [15:0] t);
    int budget;
    budget = 70000;
    while (m_timer != t && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL run_to: timer %h never reached %h", m_timer, t);
    end
  endtask

  initial begin
    logic [15:0] ua [4];
    int op;
    int sel;
    ua[0] = 16'h8000;
    ua[1] = 16'hC123;
    ua[2] = 16'hFEFF;
    ua[3] = 16'hFF10;

    reset = 1;
    tx_ready = 0;
    idle();
    repeat (3) step();
    reset = 0;
    @(negedge clk);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'h0);
    chk("rst_tx_data", {8'd0, tx_data}, 16'h0);
    chk("rst_bus_error", {15'd0, bus_error}, 16'h0);
    step();
    rd_chk("rst_status", 16'hFF01, 8'h01);
    rd_chk("rst_timer_hi", 16'hFF03, 8'h00);

    wr(16'h2000, 8'hA5);
    rd_chk("ram_2000", 16'h2000, 8'hA5);
    wr(16'h1C00, 8'h3C);
    rd_chk("ram_1c00", 16'h1C00, 8'h3C);
    wr(16'h3FFF, 8'h5A);
    rd_chk("ram_top", 16'h3FFF, 8'h5A);

    rd_chk("unmapped_rd", 16'h8000, 8'hFF);
    @(negedge clk);
    chk("err_pulse", {15'd0, bus_error}, 16'h1);
    step();
    @(negedge clk);
    chk("err_clear", {15'd0, bus_error}, 16'h0);
    rd_chk("ram_limit", 16'h4000, 8'hFF);
    drive(1, 1, 16'h2000, 8'h77);
    step();
    idle();
    @(negedge clk);
    chk("rw_err", {15'd0, bus_error}, 16'h1);
    step();
    rd_chk("rw_no_write", 16'h2000, 8'hA5);
    rd_chk("id", 16'hFF04, 8'h91);
    rd_chk("io_other", 16'hFF0A, 8'h00);

    for (int i = 1; i <= 9; i++) wr(16'hFF00, 8'(i));
    rd_chk("fifo_ovf_status", 16'hFF01, 8'h86);
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("drain_valid", {15'd0, tx_valid}, 16'h1);
      chk("drain_data", {8'd0, tx_data}, 16'(i));
      step();
    end
    @(negedge clk);
    chk("drain_empty", {15'd0, tx_valid}, 16'h0);
    tx_ready = 0;
    step();

    wr(16'hFF01, 8'h04);
    rd_chk("ovf_cleared", 16'hFF01, 8'h01);
    for (int i = 0; i < 8; i++) wr(16'hFF00, 8'h10 + 8'(i));
    rd_chk("full_status", 16'hFF01, 8'h82);
    drive(0, 1, 16'hFF00, 8'h42);
    tx_ready = 1;
    step();
    tx_ready = 0;
    idle();
    rd_chk("push_pop_full", 16'hFF01, 8'h82);
    @(negedge clk);
    chk("new_head", {8'd0, tx_data}, 16'h0011);

    drive(0, 1, 16'hFF00, 8'h33);
    reset = 1;
    step();
    reset = 0;
    idle();
    @(negedge clk);
    chk("rst_mid_valid", {15'd0, tx_valid}, 16'h0);
    chk("rst_mid_err", {15'd0, bus_error}, 16'h0);
    step();
    rd_chk("rst_mid_status", 16'hFF01, 8'h01);

    for (int i = 0; i < 600; i++) begin
      op  = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 4));
      tx_ready = 1'($urandom_range(0, 1));
      case (sel)
        0: address_bus = 16'h2000 + 16'($urandom_range(0, 7));
        1: address_bus = {12'hFF0, 4'($urandom_range(0, 15))};
        2: address_bus = 16'hFF00;
        3: address_bus = 16'hFF01;
        default: address_bus = ua[$urandom_range(0, 3)];
      endcase
      tb_d = 8'($urandom);
      r = (op <= 3) || (op == 9);
      w = (op >= 4 && op <= 7) || (op == 9);
      tb_de = w;
      step();
    end
    idle();
    tx_ready = 0;
    step();

    run_to(16'h12FE);
    rd_chk("timer_lo", 16'hFF02, 8'hFE);
    run_to(16'h1305);
    rd_chk("timer_hi_latched", 16'hFF03, 8'h12);

    run_to(16'hFFFF);
    rd_chk("timer_lo_ffff", 16'hFF02, 8'hFF);
    rd_chk("timer_hi_ff", 16'hFF03, 8'hFF);
    rd_chk("timer_wrapped", 16'hFF02, 8'h01);
    rd_chk("timer_hi_wrap", 16'hFF03, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
